// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM bus controller: state encoding,
// default bus widths and wait-state limits. Honours SRAM_WRITE_VERIFY_EN.
package sram_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 8;
    localparam int WAIT_MIN   = 1;
    localparam int WAIT_MAX   = 15;
    localparam int WAIT_CNT_W = 4;

`ifdef SRAM_WRITE_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_VREAD  = 3'd4,
        ST_VHOLD  = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/sram_wait_timer.sv
// Wait-state down-counter: load sets it to WAIT_CYCLES, done is high during the
// last counted cycle.
module sram_wait_timer
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    logic [WAIT_CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= WAIT_CNT_W'(WAIT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - WAIT_CNT_W'(1);
        end
    end

    assign done = (cnt == WAIT_CNT_W'(1));

endmodule

// File: rtl/sram_bus_ctrl.sv
// Request/response front end for an asynchronous SRAM with fixed wait states.
// Define SRAM_WRITE_VERIFY_EN to add a read-back check after every write.
module sram_bus_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq_out,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq_in,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
`ifdef SRAM_WRITE_VERIFY_EN
    ,
    output logic              o_verify_err
`endif
);

    if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
        $error("sram_bus_ctrl: WAIT_CYCLES=%0d outside %0d..%0d", WAIT_CYCLES, WAIT_MIN, WAIT_MAX);
    end

    state_t            state;
    state_t            state_nxt;
    logic              out_of_reset;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              timer_load;
    logic              timer_done;

    // Ready stays low while reset is held and rises on the first edge after release.
    assign o_req_ready   = (state == ST_IDLE) && out_of_reset;
    assign accept        = i_req_valid && o_req_ready;
    assign o_busy        = (state != ST_IDLE);
    assign o_sram_addr   = addr_q;
    assign o_sram_dq_out = wdata_q;
    assign o_rsp_rdata   = rdata_q;

    sram_wait_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_timer (
        .clk (i_clk),
        .rst (i_reset),
        .load(timer_load),
        .done(timer_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            out_of_reset <= 1'b0;
        end else begin
            state        <= state_nxt;
            out_of_reset <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= i_req_we;
                addr_q  <= i_req_addr;
                wdata_q <= i_req_wdata;
            end
            if (state == ST_ACCESS && timer_done && !we_q) begin
                rdata_q <= i_sram_dq_in;
            end
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        timer_load   = 1'b0;
        o_sram_ce_n  = 1'b1;
        o_sram_oe_n  = 1'b1;
        o_sram_we_n  = 1'b1;
        o_sram_dq_oe = 1'b0;
        o_rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                o_sram_ce_n = 1'b0;
                timer_load  = 1'b1;
                state_nxt   = ST_ACCESS;
            end
            ST_ACCESS: begin
                o_sram_ce_n = 1'b0;
                if (we_q) begin
                    o_sram_we_n  = 1'b0;
                    o_sram_dq_oe = 1'b1;
                end else begin
                    o_sram_oe_n = 1'b0;
                end
                if (timer_done) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                o_sram_ce_n  = 1'b0;
                o_sram_dq_oe = we_q;
                o_rsp_valid  = !we_q;
`ifdef SRAM_WRITE_VERIFY_EN
                if (we_q) begin
                    timer_load = 1'b1;
                    state_nxt  = ST_VREAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
`ifdef SRAM_WRITE_VERIFY_EN
            ST_VREAD: begin
                o_sram_ce_n = 1'b0;
                o_sram_oe_n = 1'b0;
                if (timer_done) state_nxt = ST_VHOLD;
            end
            ST_VHOLD: begin
                o_sram_ce_n = 1'b0;
                state_nxt   = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef SRAM_WRITE_VERIFY_EN
    logic [DATA_W-1:0] vdata_q;

    // Read-back is captured at the end of VREAD and compared during VHOLD; the flag is sticky.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vdata_q      <= '0;
            o_verify_err <= 1'b0;
        end else begin
            if (state == ST_VREAD && timer_done) vdata_q <= i_sram_dq_in;
            if (state == ST_VHOLD && vdata_q != wdata_q) o_verify_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed self-checking bench for sram_bus_ctrl with a small behavioural SRAM
// model; SRAM_WRITE_VERIFY_EN adds the read-back corruption case.
module tb_sram_bus_ctrl;

    localparam int ADDR_W      = 20;
    localparam int DATA_W      = 8;
    localparam int WAIT_CYCLES = 2;
    localparam int WIN         = 9;
`ifdef SRAM_WRITE_VERIFY_EN
    localparam int WR_NOTREADY = 3 + 2 * WAIT_CYCLES;
    localparam int WR_OE_LOW   = WAIT_CYCLES;
    localparam int WR_CE_LOW   = 3 + 2 * WAIT_CYCLES;
`else
    localparam int WR_NOTREADY = 2 + WAIT_CYCLES;
    localparam int WR_OE_LOW   = 0;
    localparam int WR_CE_LOW   = 2 + WAIT_CYCLES;
`endif

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_req_valid = 1'b0;
    logic              o_req_ready;
    logic              i_req_we = 1'b0;
    logic [ADDR_W-1:0] i_req_addr = '0;
    logic [DATA_W-1:0] i_req_wdata = '0;
    logic              o_rsp_valid;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_busy;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_dq_out;
    logic              o_sram_dq_oe;
    logic [DATA_W-1:0] i_sram_dq_in;
    logic              o_sram_ce_n;
    logic              o_sram_oe_n;
    logic              o_sram_we_n;
`ifdef SRAM_WRITE_VERIFY_EN
    logic              o_verify_err;
`endif

    sram_bus_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_busy       (o_busy),
        .o_sram_addr  (o_sram_addr),
        .o_sram_dq_out(o_sram_dq_out),
        .o_sram_dq_oe (o_sram_dq_oe),
        .i_sram_dq_in (i_sram_dq_in),
        .o_sram_ce_n  (o_sram_ce_n),
        .o_sram_oe_n  (o_sram_oe_n),
        .o_sram_we_n  (o_sram_we_n)
`ifdef SRAM_WRITE_VERIFY_EN
        ,
        .o_verify_err (o_verify_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    // SRAM model indexed by the low address nibble; can corrupt bit 0 of 0x3C writes.
    logic [DATA_W-1:0] mem [16];
    logic              corrupt = 1'b0;

    always @(posedge i_clk) begin
        if (!o_sram_ce_n && !o_sram_we_n)
            mem[o_sram_addr[3:0]] <= o_sram_dq_out ^ {7'd0, corrupt && (o_sram_dq_out == 8'h3C)};
    end

    assign i_sram_dq_in = (!o_sram_ce_n && !o_sram_oe_n) ? mem[o_sram_addr[3:0]] : 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    int we_low, oe_low, ce_low, dqoe_hi, notready, rsp_cnt, rsp_cyc, addr_bad, dq_bad, both_low;

    // Offer one request at the current negedge, then observe WIN cycles after the accept edge.
    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        we_low = 0; oe_low = 0; ce_low = 0; dqoe_hi = 0; notready = 0;
        rsp_cnt = 0; rsp_cyc = -1; addr_bad = 0; dq_bad = 0; both_low = 0;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge i_clk);
            if (!o_sram_we_n) we_low++;
            if (!o_sram_we_n && o_sram_dq_out != wdata) dq_bad++;
            if (!o_sram_oe_n) oe_low++;
            if (!o_sram_ce_n) ce_low++;
            if (o_sram_dq_oe) dqoe_hi++;
            if (!o_req_ready) notready++;
            if (o_rsp_valid) begin
                rsp_cnt++;
                rsp_cyc = c;
            end
            if (!o_sram_ce_n && o_sram_addr != addr) addr_bad++;
            if (!o_sram_we_n && !o_sram_oe_n) both_low++;
            if (o_sram_dq_oe && !o_sram_oe_n) both_low++;
            if (c == 1) begin
                i_req_valid = 1'b0;
                i_req_we    = ~we;
                i_req_wdata = ~wdata;
            end
            if (c == 2) i_req_addr = '0;
        end
    endtask

    int accepts;
    int acc_cyc [3];

    initial begin
        // Reset state while reset is held.
        repeat (2) @(negedge i_clk);
        check("rst_ready", 32'(o_req_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ce_n", 32'(o_sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(o_sram_oe_n), 32'd1);
        check("rst_we_n", 32'(o_sram_we_n), 32'd1);
        check("rst_dq_oe", 32'(o_sram_dq_oe), 32'd0);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_addr", 32'(o_sram_addr), 32'd0);
        check("rst_dq_out", 32'(o_sram_dq_out), 32'd0);
        check("rst_rdata", 32'(o_rsp_rdata), 32'd0);
        i_reset = 1'b0;
        #1;
        check("ready_before_edge", 32'(o_req_ready), 32'd0);
        @(negedge i_clk);
        check("ready_after_edge", 32'(o_req_ready), 32'd1);

        // Write 0xA5 to 0x00010.
        run_txn(1'b1, 20'h00010, 8'hA5);
        check("wr_we_low", we_low, 32'd2);
        check("wr_dqoe_hi", dqoe_hi, 32'd3);
        check("wr_notready", notready, WR_NOTREADY);
        check("wr_ce_low", ce_low, WR_CE_LOW);
        check("wr_oe_low", oe_low, WR_OE_LOW);
        check("wr_rsp_cnt", rsp_cnt, 32'd0);
        check("wr_dq_data", dq_bad, 32'd0);
        check("wr_addr", addr_bad, 32'd0);
        check("wr_both_low", both_low, 32'd0);
        check("wr_mem", 32'(mem[0]), 32'hA5);
        check("wr_ready_after", 32'(o_req_ready), 32'd1);

        // Preload the top address, then read both locations back.
        run_txn(1'b1, 20'hFFFFF, 8'h5A);
        check("wr_top_mem", 32'(mem[15]), 32'h5A);

        run_txn(1'b0, 20'h00010, 8'h00);
        check("rd_rsp_cnt", rsp_cnt, 32'd1);
        check("rd_rsp_cycle", rsp_cyc, 32'd4);
        check("rd_rdata", 32'(o_rsp_rdata), 32'hA5);
        check("rd_oe_low", oe_low, 32'd2);
        check("rd_we_low", we_low, 32'd0);
        check("rd_dqoe_hi", dqoe_hi, 32'd0);
        check("rd_notready", notready, 32'd4);

        // Top address with i_req_addr changed to 0 during ACCESS.
        run_txn(1'b0, 20'hFFFFF, 8'h00);
        check("rd_top_addr", addr_bad, 32'd0);
        check("rd_top_rsp_cnt", rsp_cnt, 32'd1);
        check("rd_top_rdata", 32'(o_rsp_rdata), 32'h5A);
        check("rd_top_both_low", both_low, 32'd0);

        // Reset asserted in the second ACCESS cycle of a write.
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 20'h00021; i_req_wdata = 8'h33;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("abort_we_before", 32'(o_sram_we_n), 32'd0);
        i_reset = 1'b1;
        #1;
        check("abort_we_n", 32'(o_sram_we_n), 32'd1);
        check("abort_ce_n", 32'(o_sram_ce_n), 32'd1);
        check("abort_dq_oe", 32'(o_sram_dq_oe), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        rsp_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            if (o_rsp_valid) rsp_cnt++;
            if (c == 1) i_reset = 1'b0;
        end
        check("abort_no_rsp", rsp_cnt, 32'd0);
        check("abort_ready", 32'(o_req_ready), 32'd1);

        // Three back-to-back reads with valid held high.
        accepts = 0; rsp_cnt = 0; both_low = 0;
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 20'h00010;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge i_clk);
            if (i_req_valid && o_req_ready) begin
                if (accepts < 3) acc_cyc[accepts] = c;
                accepts++;
            end
            if (o_rsp_valid) rsp_cnt++;
            if (!o_sram_we_n && !o_sram_oe_n) both_low++;
            if (c == 14) i_req_valid = 1'b0;
        end
        @(negedge i_clk);
        check("b2b_accepts", accepts, 32'd3);
        check("b2b_acc1", acc_cyc[1] - acc_cyc[0], 32'd5);
        check("b2b_acc2", acc_cyc[2] - acc_cyc[1], 32'd5);
        check("b2b_rsp_cnt", rsp_cnt, 32'd3);
        check("b2b_both_low", both_low, 32'd0);
        check("b2b_rdata", 32'(o_rsp_rdata), 32'hA5);

`ifdef SRAM_WRITE_VERIFY_EN
        // Corrupted write of 0x3C must raise the sticky verify flag.
        check("ver_err_init", 32'(o_verify_err), 32'd0);
        corrupt = 1'b1;
        run_txn(1'b1, 20'h00005, 8'h3C);
        @(negedge i_clk);
        check("ver_err_set", 32'(o_verify_err), 32'd1);
        corrupt = 1'b0;
        run_txn(1'b1, 20'h00006, 8'h11);
        @(negedge i_clk);
        check("ver_err_sticky", 32'(o_verify_err), 32'd1);
        i_reset = 1'b1;
        #1;
        check("ver_err_rst", 32'(o_verify_err), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
